// File: rtl/bass_sequencer.sv
// bass_sequencer: 16-step note pattern to gate/trigger/freq (Hz x 256) for the bass voice.
// Ports: clk/rst (sync, active-high); start/finish per-sample handshake; run enable;
//   wr_en/wr_addr/wr_data pattern writes {slide, rest, note[6:0]}; gate/trigger/freq to the instrument.
// Optional feature: define BASS_SEQ_SLIDE_EN to honour the slide bit (tied notes with glide).
module bass_sequencer #(
  parameter int STEPS            = 16,
  parameter int SAMPLES_PER_STEP = 6000,
  parameter int GATE_SAMPLES     = 4500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        finish,
  input  logic        run,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [8:0]  wr_data,
  output logic        gate,
  output logic        trigger,
  output logic [23:0] freq
);
  localparam int SW = $clog2(STEPS);
  localparam int KW = $clog2(SAMPLES_PER_STEP);

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_LOOKUP, S_FINISH} state_t;

  state_t        state_q, state_d;
  logic [8:0]    pat_q [STEPS];
  logic [8:0]    pat_d [STEPS];
  logic [8:0]    w_q, w_d;
  logic [KW-1:0] k_q, k_d;
  logic [SW-1:0] step_q, step_d;
  logic [6:0]    rem_q, rem_d;
  logic [3:0]    oct_q, oct_d;
  logic          run_q, run_d;
  logic          gate_q, gate_d;
  logic          trigger_q, trigger_d;
  logic [23:0]   freq_q, freq_d;

  logic [8:0]    cur_w;
  logic          cur_run;
  logic          cur_act;
  logic          new_gate;
  logic          new_trig;

`ifdef BASS_SEQ_SLIDE_EN
  logic [8:0]    wn_q, wn_d;
  logic [8:0]    cur_wn;
  // Set when the step just entered is tied to an active predecessor: its trigger is suppressed.
  logic          tie_q, tie_d;
`endif

  // Notes 108..127 and rest-flagged words are both silent.
  function automatic logic is_active(input logic [8:0] x);
    return !x[7] && (x[6:0] <= 7'd107);
  endfunction

  // Octave 8 (notes 96..107) frequencies, Hz x 256; lower octaves are right shifts.
  function automatic logic [19:0] base_of(input logic [3:0] r);
    case (r)
      4'd0:    return 20'd535808;
      4'd1:    return 20'd567670;
      4'd2:    return 20'd601425;
      4'd3:    return 20'd637188;
      4'd4:    return 20'd675078;
      4'd5:    return 20'd715220;
      4'd6:    return 20'd757750;
      4'd7:    return 20'd802808;
      4'd8:    return 20'd850546;
      4'd9:    return 20'd901120;
      4'd10:   return 20'd954702;
      default: return 20'd1011474;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    w_d       = w_q;
    k_d       = k_q;
    step_d    = step_q;
    rem_d     = rem_q;
    oct_d     = oct_q;
    run_d     = run_q;
    gate_d    = gate_q;
    trigger_d = trigger_q;
    freq_d    = freq_q;

    if (wr_en) pat_d[wr_addr[SW-1:0]] = wr_data;

    // In IDLE the sample's words come straight from the pattern (old contents if a write
    // lands in the same cycle); afterwards from the latched copies.
    cur_w    = (state_q == S_IDLE) ? pat_q[step_q] : w_q;
    cur_run  = (state_q == S_IDLE) ? run : run_q;
    cur_act  = is_active(cur_w);
    new_gate = cur_act && (k_q < KW'(GATE_SAMPLES));
    new_trig = cur_act && (k_q == '0);

`ifdef BASS_SEQ_SLIDE_EN
    wn_d   = wn_q;
    tie_d  = tie_q;
    cur_wn = (state_q == S_IDLE) ? pat_q[step_q + SW'(1)] : wn_q;
    if (cur_act && is_active(cur_wn) && cur_wn[8]) new_gate = 1'b1;
    if (tie_q) new_trig = 1'b0;
`endif

    if (!cur_run) begin
      new_gate = 1'b0;
      new_trig = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_d   = cur_w;
          run_d = run;
`ifdef BASS_SEQ_SLIDE_EN
          wn_d  = cur_wn;
`endif
          if (!run) begin
            k_d     = '0;
            step_d  = '0;
`ifdef BASS_SEQ_SLIDE_EN
            tie_d   = 1'b0;
`endif
            state_d = S_FINISH;
          end else if ((k_q == '0) && cur_act) begin
            rem_d   = cur_w[6:0];
            oct_d   = 4'd0;
            state_d = S_DIVIDE;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_DIVIDE: begin
        // Repeated subtraction: one octave per cycle, so load latency tracks the octave.
        if (rem_q >= 7'd12) begin
          rem_d = rem_q - 7'd12;
          oct_d = oct_q + 4'd1;
        end else begin
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        freq_d  = {4'd0, base_of(rem_q[3:0])} >> (4'd8 - oct_q);
        state_d = S_FINISH;
      end
      default: begin
        if (run_q) begin
          if (k_q == KW'(SAMPLES_PER_STEP - 1)) begin
            k_d    = '0;
            step_d = step_q + SW'(1);
`ifdef BASS_SEQ_SLIDE_EN
            tie_d  = is_active(w_q) && is_active(wn_q) && wn_q[8];
`endif
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        state_d = S_IDLE;
      end
    endcase

    // Outputs move only as the sample's finish cycle begins.
    if ((state_q != S_FINISH) && (state_d == S_FINISH)) begin
      gate_d    = new_gate;
      trigger_d = new_trig;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < STEPS; i++) pat_q[i] <= 9'h080;
      w_q       <= 9'h080;
      k_q       <= '0;
      step_q    <= '0;
      rem_q     <= '0;
      oct_q     <= '0;
      run_q     <= 1'b0;
      gate_q    <= 1'b0;
      trigger_q <= 1'b0;
      freq_q    <= '0;
`ifdef BASS_SEQ_SLIDE_EN
      wn_q      <= 9'h080;
      tie_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      w_q       <= w_d;
      k_q       <= k_d;
      step_q    <= step_d;
      rem_q     <= rem_d;
      oct_q     <= oct_d;
      run_q     <= run_d;
      gate_q    <= gate_d;
      trigger_q <= trigger_d;
      freq_q    <= freq_d;
`ifdef BASS_SEQ_SLIDE_EN
      wn_q      <= wn_d;
      tie_q     <= tie_d;
`endif
    end
  end

  assign finish  = (state_q == S_FINISH);
  assign gate    = gate_q;
  assign trigger = trigger_q;
  assign freq    = freq_q;

endmodule

// File: tb/tb_bass_sequencer.sv
module tb_bass_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        finish;
  logic        run = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [8:0]  wr_data = '0;
  logic        gate;
  logic        trigger;
  logic [23:0] freq;

  int checks = 0;
  int errors = 0;

  bass_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .run(run),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .gate(gate), .trigger(trigger), .freq(freq)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic write_pat(input logic [3:0] a, input logic [8:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  // One sample: returns finish cycle relative to the accepted-start cycle (-1 on timeout).
  // Returns with the DUT back in IDLE; outputs hold until the next finish.
  task automatic sample(output int lat);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    while (!finish && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!finish) lat = -1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int lat;
    do_reset();
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish: got %b want 0", finish); end
    checks++; if (gate !== 1'b0) begin errors++; $display("FAIL reset_gate: got %b want 0", gate); end
    checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL reset_trigger: got %b want 0", trigger); end
    checks++; if (freq !== 24'd0) begin errors++; $display("FAIL reset_freq: got %0d want 0", freq); end
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sample(lat);
      checks++;
      if (lat !== 1 || gate !== 1'b0 || trigger !== 1'b0 || freq !== 24'd0) begin
        errors++;
        $display("FAIL rest_sample%0d: lat=%0d gate=%b trig=%b freq=%0d want lat=1 0 0 0", i, lat, gate, trigger, freq);
      end
    end
  endtask

  // Note 69 at step 0: load, then hold through the step; gate falls at k=4500.
  task automatic test_note69_step();
    int lat;
    do_reset();
    run = 1'b1;
    write_pat(4'd0, 9'h045);
    sample(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL n69_latency: got %0d want 8", lat); end
    checks++; if (freq !== 24'd112640) begin errors++; $display("FAIL n69_freq: got %0d want 112640", freq); end
    checks++; if (gate !== 1'b1 || trigger !== 1'b1) begin errors++; $display("FAIL n69_gt: gate=%b trig=%b want 1 1", gate, trigger); end
    sample(lat);
    checks++; if (lat !== 1 || gate !== 1'b1 || trigger !== 1'b0) begin errors++; $display("FAIL n69_k1: lat=%0d gate=%b trig=%b want 1 1 0", lat, gate, trigger); end
    for (int k = 2; k < 6000; k++) begin
      sample(lat);
      checks++;
      if (lat !== 1 || gate !== (k < 4500) || trigger !== 1'b0) begin
        errors++;
        $display("FAIL n69_k%0d: lat=%0d gate=%b trig=%b want 1 %b 0", k, lat, gate, trigger, (k < 4500));
      end
    end
    sample(lat);
    checks++;
    if (lat !== 1 || gate !== 1'b0 || trigger !== 1'b0 || freq !== 24'd112640) begin
      errors++;
      $display("FAIL step1_rest: lat=%0d gate=%b trig=%b freq=%0d want 1 0 0 112640", lat, gate, trigger, freq);
    end
  endtask

  task automatic test_note_range();
    int lat;
    do_reset();
    run = 1'b1;
    write_pat(4'd0, 9'h000);
    sample(lat);
    checks++; if (lat !== 3 || freq !== 24'd2093) begin errors++; $display("FAIL note0: lat=%0d freq=%0d want 3 2093", lat, freq); end
    do_reset();
    write_pat(4'd0, 9'h06B);
    sample(lat);
    checks++; if (lat !== 11 || freq !== 24'd1011474) begin errors++; $display("FAIL note107: lat=%0d freq=%0d want 11 1011474", lat, freq); end
    do_reset();
    write_pat(4'd0, 9'h06E);
    sample(lat);
    checks++;
    if (lat !== 1 || gate !== 1'b0 || trigger !== 1'b0 || freq !== 24'd0) begin
      errors++;
      $display("FAIL note110: lat=%0d gate=%b trig=%b freq=%0d want 1 0 0 0", lat, gate, trigger, freq);
    end
  endtask

  // Step 0 = 69, step 1 = 72 with slide bit.
  task automatic test_slide();
    int lat;
    logic exp_tail_gate;
    logic exp_trig1;
`ifdef BASS_SEQ_SLIDE_EN
    exp_tail_gate = 1'b1;
    exp_trig1     = 1'b0;
`else
    exp_tail_gate = 1'b0;
    exp_trig1     = 1'b1;
`endif
    do_reset();
    run = 1'b1;
    write_pat(4'd0, 9'h045);
    write_pat(4'd1, 9'h148);
    for (int k = 0; k < 6000; k++) begin
      sample(lat);
      if (k == 4500) begin
        checks++; if (gate !== exp_tail_gate) begin errors++; $display("FAIL slide_gate_k4500: got %b want %b", gate, exp_tail_gate); end
      end
      if (k == 5999) begin
        checks++; if (gate !== exp_tail_gate) begin errors++; $display("FAIL slide_gate_k5999: got %b want %b", gate, exp_tail_gate); end
      end
    end
    sample(lat);
    checks++; if (lat !== 9 || freq !== 24'd133952) begin errors++; $display("FAIL slide_step1_load: lat=%0d freq=%0d want 9 133952", lat, freq); end
    checks++; if (trigger !== exp_trig1 || gate !== 1'b1) begin errors++; $display("FAIL slide_step1_gt: trig=%b gate=%b want %b 1", trigger, gate, exp_trig1); end
  endtask

  task automatic test_run_and_rst_divide();
    int lat;
    int seen;
    do_reset();
    run = 1'b1;
    write_pat(4'd0, 9'h045);
    sample(lat);
    run = 1'b0;
    sample(lat);
    checks++;
    if (lat !== 1 || gate !== 1'b0 || trigger !== 1'b0 || freq !== 24'd112640) begin
      errors++;
      $display("FAIL run0_sample: lat=%0d gate=%b trig=%b freq=%0d want 1 0 0 112640", lat, gate, trigger, freq);
    end
    run = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 0;
    repeat (2) begin
      @(posedge clk);
      #1 if (finish) seen++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) begin
      if (finish) seen++;
      @(posedge clk);
      #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_divide_finish: got %0d pulses want 0", seen); end
    checks++; if (gate !== 1'b0 || trigger !== 1'b0 || freq !== 24'd0) begin errors++; $display("FAIL rst_divide_out: gate=%b trig=%b freq=%0d want 0 0 0", gate, trigger, freq); end
  endtask

  task automatic test_write_collision();
    int lat;
    do_reset();
    run = 1'b1;
    @(negedge clk);
    start = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 9'h045;
    @(posedge clk);
    #1 start = 1'b0; wr_en = 1'b0;
    lat = 1;
    while (!finish && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!finish) lat = -1;
    checks++; if (lat !== 1 || gate !== 1'b0 || freq !== 24'd0) begin errors++; $display("FAIL collide_old_word: lat=%0d gate=%b freq=%0d want 1 0 0", lat, gate, freq); end
    @(posedge clk);
    #1;
    sample(lat);
    checks++; if (lat !== 1 || gate !== 1'b1 || trigger !== 1'b0) begin errors++; $display("FAIL collide_new_word: lat=%0d gate=%b trig=%b want 1 1 0", lat, gate, trigger); end
  endtask

  initial begin
    test_reset();
    test_note69_step();
    test_note_range();
    test_slide();
    test_run_and_rst_divide();
    test_write_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
